// File: rtl/group_credit_fifo.sv
// group_credit_fifo: ring of whole-group slots between SFTM and DPM, one credit pulse per drained group.
// Build option: define GCF_ABORT_EN to let wr_abort discard the partially written group.
module group_credit_fifo #(
  parameter int DATA_W       = 16,
  parameter int LANES        = 4,
  parameter int GROUP_BEATS  = 4,
  parameter int DEPTH_GROUPS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [LANES*DATA_W-1:0]         wr_data,
  input  logic                            wr_last,
  input  logic                            wr_abort,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [LANES*DATA_W-1:0]         rd_data,
  output logic                            rd_last,
  output logic                            credit_ret,
  output logic [$clog2(DEPTH_GROUPS):0]   groups_free,
  output logic [1:0]                      err,
  input  logic                            err_clr
);

  localparam int BEAT_W = LANES * DATA_W;
  localparam int SLOT_W = $clog2(DEPTH_GROUPS);
  localparam int BIDX_W = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH_GROUPS);
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(GROUP_BEATS - 1);

  if (DEPTH_GROUPS < 2 || (DEPTH_GROUPS & (DEPTH_GROUPS - 1)) != 0) begin : g_bad_depth
    $error("group_credit_fifo: DEPTH_GROUPS must be a power of two >= 2");
  end

  logic [BEAT_W-1:0] mem [DEPTH_GROUPS][GROUP_BEATS];
  // Index of the final beat of each committed slot (group length minus one).
  logic [BIDX_W-1:0] last_idx [DEPTH_GROUPS];

  logic [SLOT_W-1:0] wslot;
  logic [SLOT_W-1:0] rslot;
  logic [BIDX_W-1:0] wbeat;
  logic [BIDX_W-1:0] rbeat;
  logic [CNT_W-1:0]  ccnt;
  logic [CNT_W-1:0]  ccnt_nxt;

  logic wr_fire;
  logic rd_fire;
  logic drop;
  logic abort;
  logic commit;
  logic overlen;
  logic final_pop;

`ifdef GCF_ABORT_EN
  assign abort = wr_abort;
`else
  logic unused_abort;
  assign unused_abort = wr_abort;
  assign abort        = 1'b0;
`endif

  assign wr_ready  = (ccnt < DEPTH_C);
  assign rd_valid  = (ccnt != '0);
  assign wr_fire   = wr_valid & wr_ready;
  assign drop      = wr_valid & ~wr_ready;
  assign rd_fire   = rd_valid & rd_ready;

  // Only committed slots are ever addressed here, so the write side never aliases this read.
  assign rd_data   = mem[rslot][rbeat];
  assign rd_last   = rd_valid & (rbeat == last_idx[rslot]);
  assign final_pop = rd_fire & rd_last;

  assign commit  = wr_fire & ~abort & (wr_last | (wbeat == LAST_BEAT));
  assign overlen = wr_fire & ~abort & ~wr_last & (wbeat == LAST_BEAT);

  always_comb begin
    ccnt_nxt = ccnt;
    if (commit && !final_pop) begin
      ccnt_nxt = ccnt + CNT_W'(1);
    end else if (final_pop && !commit) begin
      ccnt_nxt = ccnt - CNT_W'(1);
    end
  end

  // Beat storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wslot][wbeat] <= wr_data;
    end
  end

  // Write side: fill pointer and per-slot length capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wslot <= '0;
      wbeat <= '0;
      for (int i = 0; i < DEPTH_GROUPS; i++) begin
        last_idx[i] <= '0;
      end
    end else if (abort) begin
      wbeat <= '0;
    end else if (commit) begin
      last_idx[wslot] <= wbeat;
      wslot           <= wslot + SLOT_W'(1);
      wbeat           <= '0;
    end else if (wr_fire) begin
      wbeat <= wbeat + BIDX_W'(1);
    end
  end

  // Read side: drain pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslot <= '0;
      rbeat <= '0;
    end else if (final_pop) begin
      rslot <= rslot + SLOT_W'(1);
      rbeat <= '0;
    end else if (rd_fire) begin
      rbeat <= rbeat + BIDX_W'(1);
    end
  end

  // Occupancy, credit and sticky errors; a new error outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt        <= '0;
      groups_free <= DEPTH_C;
      credit_ret  <= 1'b0;
      err         <= 2'b00;
    end else begin
      ccnt        <= ccnt_nxt;
      groups_free <= DEPTH_C - ccnt_nxt;
      credit_ret  <= final_pop;
      err         <= (err_clr ? 2'b00 : err) | {drop, overlen};
    end
  end

endmodule

// File: tb/tb_group_credit_fifo.sv
// Bench for group_credit_fifo: scoreboard of committed beats plus directed group scenarios.
module tb_group_credit_fifo;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int GB     = 4;
  localparam int DEPTH  = 4;
  localparam int BEAT_W = DATA_W * LANES;
`ifdef GCF_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_last = 1'b0;
  logic              wr_abort = 1'b0;
  logic              rd_ready = 1'b0;
  logic              err_clr = 1'b0;
  logic [BEAT_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_last;
  logic              credit_ret;
  logic [BEAT_W-1:0] rd_data;
  logic [2:0]        groups_free;
  logic [1:0]        err;

  always #5 clk = ~clk;

  group_credit_fifo #(
    .DATA_W(DATA_W), .LANES(LANES), .GROUP_BEATS(GB), .DEPTH_GROUPS(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .wr_abort(wr_abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .credit_ret(credit_ret), .groups_free(groups_free), .err(err), .err_clr(err_clr)
  );

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [BEAT_W-1:0] pend_q[$];
  int                m_ccnt;
  int                m_wbeat;
  logic [1:0]        m_err;
  logic              m_credit;
  int                n_tests;
  int                n_fail;
  int                n_credit;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    m_ccnt   = 0;
    m_wbeat  = 0;
    m_err    = 2'b00;
    m_credit = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model with current inputs, clock.
  task automatic cycle();
    bit    wfire, rfire, fin, commit, overlen, ab, drop;
    beat_t b;
    #1;
    chk("wr_ready", 64'(wr_ready), 64'(m_ccnt < DEPTH));
    chk("rd_valid", 64'(rd_valid), 64'(m_ccnt != 0));
    chk("groups_free", 64'(groups_free), 64'(DEPTH - m_ccnt));
    chk("credit_ret", 64'(credit_ret), 64'(m_credit));
    chk("err", 64'(err), 64'(m_err));
    if (credit_ret) n_credit++;
    if (m_ccnt != 0 && exp_q.size() != 0) begin
      chk("rd_data", rd_data, exp_q[0].data);
      chk("rd_last", 64'(rd_last), 64'(exp_q[0].last));
    end
    wfire = wr_valid && (m_ccnt < DEPTH);
    drop  = wr_valid && !(m_ccnt < DEPTH);
    ab    = ABORT_EN && wr_abort;
    rfire = rd_ready && (m_ccnt != 0) && (exp_q.size() != 0);
    fin   = 1'b0;
    if (rfire) begin
      b   = exp_q.pop_front();
      fin = b.last;
    end
    commit  = wfire && !ab && (wr_last || m_wbeat == GB - 1);
    overlen = wfire && !ab && !wr_last && m_wbeat == GB - 1;
    if (wfire) pend_q.push_back(wr_data);
    if (ab) begin
      pend_q.delete();
      m_wbeat = 0;
    end else if (commit) begin
      foreach (pend_q[i]) begin
        b.data = pend_q[i];
        b.last = (i == pend_q.size() - 1);
        exp_q.push_back(b);
      end
      pend_q.delete();
      m_wbeat = 0;
    end else if (wfire) begin
      m_wbeat++;
    end
    m_err    = (err_clr ? 2'b00 : m_err) | {drop, overlen};
    m_ccnt   = m_ccnt + int'(commit) - int'(fin);
    m_credit = fin;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_abort = 1'b0;
    rd_ready = 1'b0;
    err_clr  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr_beat(input logic [63:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    cycle();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rd_ready = 1'b1;
    while (m_ccnt != 0 && k < 200) begin
      cycle();
      k++;
    end
    rd_ready = 1'b0;
    if (k >= 200) chk("drain_timeout", 64'(rd_valid), 64'(0));
    cycle();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_credit = 0;

    // T1: reset state, then one 4-beat group read straight through
    do_reset();
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_groups_free", 64'(groups_free), 64'(4));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_credit", 64'(credit_ret), 64'(0));
    n_credit = 0;
    rd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) wr_beat(64'h0001_0001_0001_0001 * k, k == 4);
    #1;
    chk("t1_valid_after_commit", 64'(rd_valid), 64'(1));
    chk("t1_first_beat", rd_data, 64'h0001_0001_0001_0001);
    drain();
    chk("t1_credits", 64'(n_credit), 64'(1));

    // T2: fill all slots with the reader stalled, overflow beat, err_clr racing a new drop
    n_credit = 0;
    for (int g = 0; g < DEPTH; g++)
      for (int b = 0; b < GB; b++) wr_beat(64'(32'hA000 + g * 16 + b) << 16, b == GB - 1);
    #1;
    chk("t2_wr_ready_full", 64'(wr_ready), 64'(0));
    chk("t2_groups_free_full", 64'(groups_free), 64'(0));
    wr_beat(64'hDEAD_BEEF, 1'b0);
    #1;
    chk("t2_err_drop", 64'(err), 64'(2'b10));
    err_clr = 1'b1;
    wr_beat(64'hDEAD_BEEF, 1'b0);
    err_clr = 1'b0;
    #1;
    chk("t2_set_beats_clr", 64'(err), 64'(2'b10));
    drain();
    chk("t2_credits", 64'(n_credit), 64'(4));
    clear_err();

    // T3: 1-beat group followed by a 3-beat group
    n_credit = 0;
    wr_beat(64'h1111, 1'b1);
    wr_beat(64'h2221, 1'b0);
    wr_beat(64'h2222, 1'b0);
    wr_beat(64'h2223, 1'b1);
    #1;
    chk("t3_rd_last_1beat", 64'(rd_last), 64'(1));
    drain();
    chk("t3_credits", 64'(n_credit), 64'(2));

    // T4: commit and final pop in the same cycle with two groups committed
    n_credit = 0;
    wr_beat(64'h4A, 1'b1);
    wr_beat(64'h4B0, 1'b0);
    wr_beat(64'h4B1, 1'b1);
    wr_beat(64'h4C0, 1'b0);
    rd_ready = 1'b1;
    wr_beat(64'h4C1, 1'b1);
    rd_ready = 1'b0;
    #1;
    chk("t4_groups_free", 64'(groups_free), 64'(2));
    chk("t4_credit_pulse", 64'(credit_ret), 64'(1));
    drain();
    chk("t4_credits", 64'(n_credit), 64'(3));

    // T5: overlength group auto-commits and flags err[0]
    n_credit = 0;
    for (int k = 1; k <= 5; k++) wr_beat(64'h5000 + 64'(k), 1'b0);
    #1;
    chk("t5_err_overlen", 64'(err), 64'(2'b01));
    chk("t5_groups_free", 64'(groups_free), 64'(3));
    wr_beat(64'h5006, 1'b1);
    clear_err();
    #1;
    chk("t5_err_cleared", 64'(err), 64'(0));
    drain();
    chk("t5_credits", 64'(n_credit), 64'(2));

    // T6: partial group then wr_abort, then a full group
    n_credit = 0;
    wr_beat(64'h6A1, 1'b0);
    wr_beat(64'h6A2, 1'b0);
    wr_abort = 1'b1;
    cycle();
    wr_abort = 1'b0;
    for (int k = 1; k <= 4; k++) wr_beat(64'h6B0 + 64'(k), k == 4);
    drain();
    chk("t6_credits", 64'(n_credit), ABORT_EN ? 64'(1) : 64'(2));
    clear_err();

    // Reset while a group is half read: everything empties and no credit follows
    for (int k = 1; k <= 4; k++) wr_beat(64'h7000 + 64'(k), k == 4);
    rd_ready = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("mid_rst_groups_free", 64'(groups_free), 64'(4));
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'(1));
    do_reset();
    n_credit = 0;
    repeat (3) cycle();
    chk("mid_rst_no_credit", 64'(n_credit), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
